// File: rtl/bar_frame_scheduler_if.sv
// rtl/bar_frame_scheduler_if.sv - bar height stream between analysis path and scheduler
//
// Purpose: carries one bar height per beat, in bar order, with a last-beat marker
// closing each set.
//
// Signals:
//   s_valid  producer has a height on s_data
//   s_ready  scheduler accepts a beat this cycle
//   s_data   bar height (HW bits)
//   s_last   final beat of a set
//
// Modports:
//   master   producer side (audio analysis path)
//   slave    consumer side (bar_frame_scheduler)

interface bar_frame_scheduler_if #(
  parameter int HW = 9
);
  logic          s_valid;
  logic          s_ready;
  logic [HW-1:0] s_data;
  logic          s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/bar_frame_scheduler.sv
// rtl/bar_frame_scheduler.sv - double-buffered spectrum bar scheduler for the VGA path
//
// Purpose: collects one complete set of NBARS bar heights per frame into a back
// bank and swaps it to the display only at the start of vertical blanking, so a
// frame never mixes old and new bars. Also turns the VGA horizontal counter into
// the bar index and front-bank height under the current column.
//
// Ports:
//   vgaclk      pixel clock, the only clock
//   rst         synchronous active-high reset
//   hc, vc      VGA horizontal (0..799) and vertical (0..524) counters
//   s           bar height stream (slave modport of bar_frame_scheduler_if)
//   bar_idx     bar under the column given by hc one cycle earlier
//   bar_height  front-bank height of bar_idx
//   swap_pulse  one-cycle pulse when the banks swap
//   set_err     one-cycle pulse when a malformed set is discarded
//   frame_miss  one-cycle pulse when vblank starts without a complete set

module bar_frame_scheduler #(
  parameter  int NBARS = 16,
  parameter  int BAR_W = 40,
  parameter  int HW    = 9,
  localparam int IW    = $clog2(NBARS)
) (
  input  logic                  vgaclk,
  input  logic                  rst,
  input  logic [9:0]            hc,
  input  logic [9:0]            vc,
  bar_frame_scheduler_if.slave  s,
  output logic [IW-1:0]         bar_idx,
  output logic [HW-1:0]         bar_height,
  output logic                  swap_pulse,
  output logic                  set_err,
  output logic                  frame_miss
);

  localparam int            CW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [IW-1:0] WP_LAST  = IW'(NBARS - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(BAR_W - 1);
  localparam logic [9:0]    ACTIVE_W = 10'(NBARS * BAR_W);
  localparam logic [9:0]    VBLANK_V = 10'd480;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  // ---------------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------------
  wr_state_t     state, state_n;
  logic [IW-1:0] wp, wp_n;
  logic          front_sel, front_sel_n;
  logic          swap_n, err_n, miss_n;
  logic          wr_en;
  logic          vblank;

  logic [HW-1:0] bank_a [NBARS];
  logic [HW-1:0] bank_b [NBARS];

  assign vblank    = (hc == 10'd0) && (vc == VBLANK_V);
  // Ready depends on the state register alone so the producer never sees a
  // combinational path from its own valid.
  assign s.s_ready = (state == FILL);

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state      <= FILL;
      wp         <= '0;
      front_sel  <= 1'b0;
      swap_pulse <= 1'b0;
      set_err    <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      state      <= state_n;
      wp         <= wp_n;
      front_sel  <= front_sel_n;
      swap_pulse <= swap_n;
      set_err    <= err_n;
      frame_miss <= miss_n;
    end
  end

  always_comb begin
    state_n     = state;
    wp_n        = wp;
    front_sel_n = front_sel;
    swap_n      = 1'b0;
    err_n       = 1'b0;
    miss_n      = 1'b0;
    wr_en       = 1'b0;

    case (state)
      FILL: begin
        if (s.s_valid) begin
          wr_en = 1'b1;
          if ((wp == WP_LAST) && s.s_last) begin
            state_n = FULL;
            wp_n    = '0;
          end else if ((wp == WP_LAST) || s.s_last) begin
            // Last marker early or missing: drop the whole set and restart.
            err_n = 1'b1;
            wp_n  = '0;
          end else begin
            wp_n = wp + IW'(1);
          end
        end
        // Vblank while still filling: any partial set is dropped. A set that
        // completes on this very cycle still moves to FULL above and waits
        // for the next vblank.
        if (vblank) begin
          miss_n = 1'b1;
          wp_n   = '0;
        end
      end
      FULL: begin
        if (vblank) begin
          front_sel_n = ~front_sel;
          swap_n      = 1'b1;
          state_n     = FILL;
          wp_n        = '0;
        end
      end
      default: begin
        state_n = FILL;
        wp_n    = '0;
      end
    endcase
  end

  // Writes always target the bank that is not displayed. No write can coincide
  // with a swap because swaps only happen in FULL, where s_ready is low.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      for (int i = 0; i < NBARS; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel) begin
        bank_a[wp] <= s.s_data;
      end else begin
        bank_b[wp] <= s.s_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: column tracking without a divider
  // ---------------------------------------------------------------------------
  // pred_off/pred_idx hold the position expected for this cycle's hc, assuming
  // hc advanced by one. hc == 0 re-anchors the count at the start of each line.
  logic [CW-1:0] pred_off, cur_off, nxt_off;
  logic [IW-1:0] pred_idx, cur_idx, nxt_idx;

  always_comb begin
    cur_off = pred_off;
    cur_idx = pred_idx;
    if (hc == 10'd0) begin
      cur_off = '0;
      cur_idx = '0;
    end
    nxt_off = cur_off + CW'(1);
    nxt_idx = cur_idx;
    if (cur_off == OFF_LAST) begin
      nxt_off = '0;
      nxt_idx = cur_idx + IW'(1);
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      pred_off <= '0;
      pred_idx <= '0;
      bar_idx  <= '0;
    end else begin
      pred_off <= nxt_off;
      pred_idx <= nxt_idx;
      bar_idx  <= (hc < ACTIVE_W) ? cur_idx : '0;
    end
  end

  // Read from the registered index and current front select, so the height
  // lines up with bar_idx and shows the new bank from the swap cycle onward.
  assign bar_height = front_sel ? bank_b[bar_idx] : bank_a[bar_idx];

endmodule

// File: tb/tb_bar_frame_scheduler.sv
// tb/tb_bar_frame_scheduler.sv - scoreboard bench for bar_frame_scheduler

module tb_bar_frame_scheduler;

  localparam int NBARS   = 16;
  localparam int BAR_W   = 40;
  localparam int HW      = 9;
  localparam int IW      = 4;
  localparam int NFRAMES = 13;

  logic          vgaclk = 1'b0;
  logic          rst    = 1'b1;
  logic [9:0]    hc     = '0;
  logic [9:0]    vc     = '0;
  logic [IW-1:0] bar_idx;
  logic [HW-1:0] bar_height;
  logic          swap_pulse;
  logic          set_err;
  logic          frame_miss;

  bar_frame_scheduler_if #(.HW(HW)) sif ();

  bar_frame_scheduler #(.NBARS(NBARS), .BAR_W(BAR_W), .HW(HW)) dut (
    .vgaclk     (vgaclk),
    .rst        (rst),
    .hc         (hc),
    .vc         (vc),
    .s          (sif),
    .bar_idx    (bar_idx),
    .bar_height (bar_height),
    .swap_pulse (swap_pulse),
    .set_err    (set_err),
    .frame_miss (frame_miss)
  );

  always #20 vgaclk = ~vgaclk;

  typedef struct {
    logic [HW-1:0] data;
    bit            last;
    bit            at_vb;
  } beat_t;

  typedef struct {
    bit rdy;
    int idx;
    int hgt;
    bit chk_idx;
    bit chk_hgt;
  } exp_t;

  typedef struct {
    int cyc;
    int kind;
  } pulse_t;

  beat_t  plan[$];
  exp_t   exp_q[$];
  pulse_t pq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  // Reference model: a set is a list of heights; it becomes displayable only
  // when exactly NBARS beats arrive with the marker on the last one.
  int m_front[NBARS];
  int m_set[NBARS];
  int pending[$];
  bit m_full;
  int m_idx;
  bit m_synced;

  // Timeline: each frame is four 800-pixel lines, vc = 0, 1, 480, 481.
  int vcs[4] = '{0, 1, 480, 481};
  int hpos;
  int li;
  int frame = -1;
  int rst_left = 1;
  bit presenting = 1'b0;

  always @(posedge vgaclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic bit front_zero();
    for (int i = 0; i < NBARS; i++) if (m_front[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NBARS; i++) begin
      m_front[i] = 0;
      m_set[i]   = 0;
    end
    pending.delete();
    m_full   = 1'b0;
    m_idx    = 0;
    m_synced = 1'b0;
  endtask

  task automatic push_set(input int n, input int last_at, input bit vb_last, input bit rnd);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.data  = rnd ? HW'($urandom_range(0, 480)) : HW'(i * 10);
      b.last  = (i == last_at);
      b.at_vb = vb_last && (i == n);
      plan.push_back(b);
    end
  endtask

  task automatic scenario(input int f);
    int k;
    case (f)
      0:  push_set(16, 16, 1'b0, 1'b0);
      1:  push_set(7, 0, 1'b0, 1'b1);
      2:  push_set(16, 16, 1'b0, 1'b1);
      3:  begin
            push_set(5, 5, 1'b0, 1'b1);
            push_set(16, 0, 1'b0, 1'b1);
          end
      4:  push_set(16, 16, 1'b1, 1'b1);
      5:  push_set(16, 16, 1'b0, 1'b1);
      7, 8, 9: begin
            k = $urandom_range(0, 2);
            if (k == 0)      push_set(16, 16, 1'b0, 1'b1);
            else if (k == 1) push_set($urandom_range(1, 15), 0, 1'b0, 1'b1);
            else             push_set(16, $urandom_range(1, 15), 1'b0, 1'b1);
          end
      10, 11, 12: push_set(16, 16, 1'b0, 1'b1);
      default: ;
    endcase
  endtask

  task automatic step();
    exp_t e;
    bit   vb, acc, full0, do_swap, do_err, do_miss;
    pulse_t p;
    @(posedge vgaclk);
    #1;
    mon_on    = 1'b1;
    e.rdy     = !m_full;
    e.idx     = m_idx;
    e.hgt     = m_front[m_idx];
    e.chk_idx = m_synced;
    e.chk_hgt = m_synced || front_zero();
    exp_q.push_back(e);

    hc = 10'(hpos);
    vc = 10'(vcs[li]);
    vb = (hpos == 0) && (vcs[li] == 480);
    if (hpos == 0 && li == 0) begin
      frame++;
      scenario(frame);
    end
    if (frame == 10 && li == 0 && hpos == 8)   rst_left = 2;
    if (frame == 10 && li == 0 && hpos == 300) push_set(16, 16, 1'b0, 1'b1);
    rst = (rst_left > 0);
    if (rst_left > 0) rst_left--;

    do_swap = 1'b0;
    do_err  = 1'b0;
    do_miss = 1'b0;
    if (rst) begin
      plan.delete();
      presenting  = 1'b0;
      sif.s_valid = 1'b0;
      model_reset();
    end else begin
      if (!presenting && plan.size() > 0) begin
        if (plan[0].at_vb ? vb : ($urandom_range(0, 3) != 0)) presenting = 1'b1;
      end
      sif.s_valid = presenting;
      if (presenting) begin
        sif.s_data = plan[0].data;
        sif.s_last = plan[0].last;
      end

      full0 = m_full;
      acc   = presenting && !m_full;
      if (acc) begin
        pending.push_back(int'(plan[0].data));
        if (plan[0].last && pending.size() == NBARS) begin
          for (int i = 0; i < NBARS; i++) m_set[i] = pending[i];
          m_full = 1'b1;
          pending.delete();
        end else if (plan[0].last || pending.size() == NBARS) begin
          do_err = 1'b1;
          pending.delete();
        end
        void'(plan.pop_front());
        presenting = 1'b0;
      end
      if (vb) begin
        if (full0) begin
          for (int i = 0; i < NBARS; i++) m_front[i] = m_set[i];
          m_full  = 1'b0;
          do_swap = 1'b1;
        end else begin
          do_miss = 1'b1;
          pending.delete();
        end
      end
      m_idx = (hpos < NBARS * BAR_W) ? hpos / BAR_W : 0;
      if (hpos == 0) m_synced = 1'b1;
    end

    p.cyc = cyc + 1;
    if (do_swap) begin p.kind = 0; pq.push_back(p); end
    if (do_err)  begin p.kind = 1; pq.push_back(p); end
    if (do_miss) begin p.kind = 2; pq.push_back(p); end

    hpos++;
    if (hpos == 800) begin
      hpos = 0;
      li   = (li + 1) % 4;
    end
  endtask

  always @(negedge vgaclk) begin
    exp_t  e;
    string pn[3];
    int    act[3];
    bit    want;
    pn  = '{"swap_pulse", "set_err", "frame_miss"};
    act = '{int'(swap_pulse), int'(set_err), int'(frame_miss)};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("s_ready", int'(sif.s_ready), int'(e.rdy));
      if (e.chk_idx) check("bar_idx", int'(bar_idx), e.idx);
      if (e.chk_hgt) check("bar_height", int'(bar_height), e.hgt);
    end
    if (mon_on) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s stale cyc=%0d actual=absent required=pulse@%0d",
                 pn[pq[0].kind], cyc, pq[0].cyc);
        void'(pq.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        want = (pq.size() > 0) && (pq[0].cyc == cyc) && (pq[0].kind == k);
        if (act[k] != 0 || want) begin
          check(pn[k], act[k], int'(want));
          if (want) void'(pq.pop_front());
        end
      end
    end
  end

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    hpos = $urandom_range(0, 799);
    li   = $urandom_range(0, 3);
    hc   = 10'(hpos);
    vc   = 10'(vcs[li]);
    model_reset();
    while (frame < NFRAMES) step();
    for (int i = 0; i < 4; i++) step();
    @(posedge vgaclk);
    #1;
    check("pulse_queue_empty", pq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
